ste_dmasnd_fifo: RTL and testbench



---
 rtl/ste_dmasnd_fifo_if.sv | 10 +
 rtl/ste_dmasnd_fifo.sv | 147 ++++++++++++++
 tb/tb_ste_dmasnd_fifo.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ste_dmasnd_fifo_if.sv
// MCU-side sound DMA handshake: active-low load strobe, fetched data word,
// and the refill request returned by the sample buffer.
interface ste_dmasnd_fifo_if;
    logic        sload_n;
    logic [15:0] din;
    logic        sreq;

    modport master (output sload_n, output din, input sreq);
    modport slave  (input sload_n, input din, output sreq);
endinterface

// File: rtl/ste_dmasnd_fifo.sv
// STE DMA sound sample buffer: 4-word FIFO filled by SLOAD_N strobes, drained
// as signed 8-bit stereo/mono samples at one of four rates from the 8 MHz enable.
module ste_dmasnd_fifo (
    input  logic              clk32,
    input  logic              porb,
    input  logic              mhz8_en,
    input  logic              sndon,
    input  logic [1:0]        rate,
    input  logic              mono,
    ste_dmasnd_fifo_if.slave  bus,
    output logic [7:0]        left,
    output logic [7:0]        right,
    output logic              sample_stb,
    output logic              underrun,
    output logic              overflow
);
    logic [15:0] mem_q [4];
    logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]  count_q, count_d;
    logic [10:0] div_q, div_d;
    logic        phase_q, phase_d;
    logic        sload_prev_q, sndon_prev_q;
    logic        sreq_q, sreq_d;
    logic [7:0]  left_q, left_d, right_q, right_d;
    logic        stb_q, stb_d, under_q, under_d, over_q, over_d;

    logic [10:0] period_m1;
    logic [15:0] head;
    logic [7:0]  mono_byte;
    logic        load_edge, tick, have_data, pop, push;

    always_comb begin
        case (rate)
            2'd0:    period_m1 = 11'd1279;
            2'd1:    period_m1 = 11'd639;
            2'd2:    period_m1 = 11'd319;
            default: period_m1 = 11'd159;
        endcase
    end

    assign head      = mem_q[rptr_q];
    assign mono_byte = phase_q ? head[7:0] : head[15:8];
    assign load_edge = sndon & sload_prev_q & ~bus.sload_n;
    // >= rather than == so that shortening the period mid-count fires promptly
    assign tick      = sndon & mhz8_en & (div_q >= period_m1);
    assign have_data = (count_q != 3'd0);
    assign pop       = tick & have_data & (~mono | phase_q);
    // a pop in the same cycle frees the slot a full-FIFO load needs
    assign push      = load_edge & ((count_q != 3'd4) | pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        div_d   = div_q;
        phase_d = phase_q;
        left_d  = left_q;
        right_d = right_q;
        under_d = under_q;
        over_d  = over_q;
        stb_d   = 1'b0;
        sreq_d  = 1'b0;
        if (!sndon) begin
            wptr_d  = 2'd0;
            rptr_d  = 2'd0;
            count_d = 3'd0;
            div_d   = 11'd0;
            phase_d = 1'b0;
            left_d  = 8'h00;
            right_d = 8'h00;
        end else begin
            sreq_d = (count_q <= 3'd2);
            if (mhz8_en)
                div_d = tick ? 11'd0 : div_q + 11'd1;
            if (push)
                wptr_d = wptr_q + 2'd1;
            if (pop)
                rptr_d = rptr_q + 2'd1;
            count_d = count_q + {2'b00, push} - {2'b00, pop};
            if (!sndon_prev_q) begin
                under_d = 1'b0;
                over_d  = 1'b0;
            end
            if (load_edge && !push)
                over_d = 1'b1;
            if (tick) begin
                if (!have_data) begin
                    under_d = 1'b1;
                end else if (!mono) begin
                    stb_d   = 1'b1;
                    left_d  = head[15:8];
                    right_d = head[7:0];
                    phase_d = 1'b0;
                end else begin
                    stb_d   = 1'b1;
                    left_d  = mono_byte;
                    right_d = mono_byte;
                    phase_d = ~phase_q;
                end
            end
        end
    end

    always_ff @(posedge clk32) begin
        if (push)
            mem_q[wptr_q] <= bus.din;
    end

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            wptr_q       <= 2'd0;
            rptr_q       <= 2'd0;
            count_q      <= 3'd0;
            div_q        <= 11'd0;
            phase_q      <= 1'b0;
            sload_prev_q <= 1'b1;
            sndon_prev_q <= 1'b0;
            sreq_q       <= 1'b0;
            left_q       <= 8'h00;
            right_q      <= 8'h00;
            stb_q        <= 1'b0;
            under_q      <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            sload_prev_q <= bus.sload_n;
            sndon_prev_q <= sndon;
            sreq_q       <= sreq_d;
            left_q       <= left_d;
            right_q      <= right_d;
            stb_q        <= stb_d;
            under_q      <= under_d;
            over_q       <= over_d;
        end
    end

    assign bus.sreq   = sreq_q;
    assign left       = left_q;
    assign right      = right_q;
    assign sample_stb = stb_q;
    assign underrun   = under_q;
    assign overflow   = over_q;
endmodule

// File: tb/tb_ste_dmasnd_fifo.sv
// Bench for ste_dmasnd_fifo: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a queue-based model.
module tb_ste_dmasnd_fifo;
    logic       clk32 = 1'b0;
    logic       porb = 1'b0;
    logic       mhz8_en = 1'b0;
    logic       sndon = 1'b0;
    logic [1:0] rate = 2'd3;
    logic       mono = 1'b0;
    logic [7:0] left, right;
    logic       sample_stb, underrun, overflow;

    ste_dmasnd_fifo_if bus();

    ste_dmasnd_fifo dut (
        .clk32      (clk32),
        .porb       (porb),
        .mhz8_en    (mhz8_en),
        .sndon      (sndon),
        .rate       (rate),
        .mono       (mono),
        .bus        (bus),
        .left       (left),
        .right      (right),
        .sample_stb (sample_stb),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    always #5 clk32 = ~clk32;

    int checks = 0;
    int errors = 0;
    int ph = 0;
    int en_cnt = 0;
    bit gate = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mq[$];
    bit          m_phase = 1'b0, m_prev_sload = 1'b1, m_prev_sndon = 1'b0;
    bit          m_tick, m_fell;
    int          m_div = 0, m_n;
    logic [15:0] m_word;
    logic [7:0]  e_left = 8'h00, e_right = 8'h00;
    bit          e_stb = 1'b0, e_sreq = 1'b0, e_under = 1'b0, e_over = 1'b0;

    always @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            mq.delete();
            m_phase = 1'b0; m_div = 0; m_prev_sload = 1'b1; m_prev_sndon = 1'b0;
            e_left = 8'h00; e_right = 8'h00; e_stb = 1'b0; e_sreq = 1'b0;
            e_under = 1'b0; e_over = 1'b0;
        end else begin
            if (!sndon) begin
                mq.delete();
                m_phase = 1'b0; m_div = 0;
                e_left = 8'h00; e_right = 8'h00; e_stb = 1'b0; e_sreq = 1'b0;
            end else begin
                m_n    = 1280 >> rate;
                m_tick = mhz8_en && (m_div >= m_n - 1);
                if (mhz8_en) m_div = m_tick ? 0 : m_div + 1;
                m_fell = m_prev_sload && !bus.sload_n;
                e_sreq = (mq.size() <= 2);
                e_stb  = 1'b0;
                if (!m_prev_sndon) begin
                    e_under = 1'b0;
                    e_over  = 1'b0;
                end
                if (m_tick) begin
                    if (mq.size() == 0) begin
                        e_under = 1'b1;
                    end else begin
                        e_stb = 1'b1;
                        if (!mono) begin
                            m_word  = mq.pop_front();
                            e_left  = m_word[15:8];
                            e_right = m_word[7:0];
                            m_phase = 1'b0;
                        end else if (!m_phase) begin
                            m_word  = mq[0];
                            e_left  = m_word[15:8];
                            e_right = m_word[15:8];
                            m_phase = 1'b1;
                        end else begin
                            m_word  = mq.pop_front();
                            e_left  = m_word[7:0];
                            e_right = m_word[7:0];
                            m_phase = 1'b0;
                        end
                    end
                end
                if (m_fell) begin
                    if (mq.size() < 4) mq.push_back(bus.din);
                    else e_over = 1'b1;
                end
            end
            m_prev_sload = bus.sload_n;
            m_prev_sndon = sndon;
        end
    end

    always @(negedge clk32) begin
        chk("m_sreq",     {15'd0, bus.sreq},   {15'd0, e_sreq});
        chk("m_left",     {8'd0, left},        {8'd0, e_left});
        chk("m_right",    {8'd0, right},       {8'd0, e_right});
        chk("m_stb",      {15'd0, sample_stb}, {15'd0, e_stb});
        chk("m_underrun", {15'd0, underrun},   {15'd0, e_under});
        chk("m_overflow", {15'd0, overflow},   {15'd0, e_over});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk32);
            #1;
            ph = (ph + 1) % 4;
            mhz8_en = gate && (ph == 0);
            if (mhz8_en) en_cnt++;
        end
    endtask

    task automatic load(input logic [15:0] w);
        bus.din = w;
        bus.sload_n = 1'b0;
        cyc(1);
        bus.sload_n = 1'b1;
        cyc(1);
    endtask

    task automatic restart(input bit g);
        gate = 1'b0;
        sndon = 1'b0;
        cyc(2);
        sndon = 1'b1;
        en_cnt = 0;
        gate = g;
    endtask

    task automatic wait_stb(input int budget, output int gap);
        gap = 0;
        do begin
            cyc(1);
            gap++;
        end while (!sample_stb && gap < budget);
        checks++;
        if (!sample_stb) begin
            errors++;
            $display("FAIL stb_timeout: no sample_stb within %0d cycles", budget);
        end
    endtask

    int gap, pulses, low_len;

    initial begin
        bus.sload_n = 1'b1;
        bus.din = 16'h0000;

        // reset state, then sreq one cycle after release
        sndon = 1'b1;
        cyc(3);
        chk("rst_sreq", {15'd0, bus.sreq}, 16'd0);
        chk("rst_left", {8'd0, left}, 16'd0);
        chk("rst_right", {8'd0, right}, 16'd0);
        chk("rst_stb", {15'd0, sample_stb}, 16'd0);
        chk("rst_under", {15'd0, underrun}, 16'd0);
        chk("rst_over", {15'd0, overflow}, 16'd0);
        porb = 1'b1;
        chk("rel_sreq0", {15'd0, bus.sreq}, 16'd0);
        cyc(1);
        chk("rel_sreq1", {15'd0, bus.sreq}, 16'd1);

        // stereo at 50 kHz
        rate = 2'd3; mono = 1'b0;
        restart(1);
        load(16'h7F80);
        load(16'h0102);
        wait_stb(1000, gap);
        chk("st_left0", {8'd0, left}, 16'h7F);
        chk("st_right0", {8'd0, right}, 16'h80);
        wait_stb(1000, gap);
        chk("st_gap", gap[15:0], 16'd640);
        chk("st_left1", {8'd0, left}, 16'h01);
        chk("st_right1", {8'd0, right}, 16'h02);

        // asynchronous reset mid-stream
        load(16'h3344);
        cyc(50);
        @(posedge clk32);
        #3 porb = 1'b0;
        #1;
        chk("ar_left", {8'd0, left}, 16'd0);
        chk("ar_right", {8'd0, right}, 16'd0);
        chk("ar_sreq", {15'd0, bus.sreq}, 16'd0);
        chk("ar_stb", {15'd0, sample_stb}, 16'd0);
        cyc(2);
        porb = 1'b1;
        cyc(1);
        chk("ar_sreq1", {15'd0, bus.sreq}, 16'd1);

        // mono at 6.25 kHz, then underrun with outputs held
        rate = 2'd0; mono = 1'b1;
        restart(1);
        load(16'hA55A);
        wait_stb(6000, gap);
        chk("mo_left0", {8'd0, left}, 16'hA5);
        chk("mo_right0", {8'd0, right}, 16'hA5);
        wait_stb(6000, gap);
        chk("mo_gap", gap[15:0], 16'd5120);
        chk("mo_left1", {8'd0, left}, 16'h5A);
        chk("mo_right1", {8'd0, right}, 16'h5A);
        pulses = 0;
        gap = 0;
        while (!underrun && gap < 6000) begin
            cyc(1);
            gap++;
            if (sample_stb) pulses++;
        end
        chk("ur_flag", {15'd0, underrun}, 16'd1);
        chk("ur_nostb", pulses[15:0], 16'd0);
        chk("ur_left", {8'd0, left}, 16'h5A);
        chk("ur_right", {8'd0, right}, 16'h5A);
        sndon = 1'b0;
        cyc(3);
        chk("ur_sticky", {15'd0, underrun}, 16'd1);
        sndon = 1'b1;
        cyc(1);
        chk("ur_clear", {15'd0, underrun}, 16'd0);

        // flow control with ticks stalled
        rate = 2'd3; mono = 1'b0;
        restart(0);
        load(16'hA1A2);
        chk("fc_sreq1", {15'd0, bus.sreq}, 16'd1);
        load(16'hB1B2);
        chk("fc_sreq2", {15'd0, bus.sreq}, 16'd1);
        load(16'hC1C2);
        chk("fc_sreq3", {15'd0, bus.sreq}, 16'd0);
        load(16'hD1D2);
        chk("fc_over4", {15'd0, overflow}, 16'd0);
        gate = 1'b1;
        gap = 0;
        while (!(mhz8_en && en_cnt == 160) && gap < 2000) begin
            cyc(1);
            gap++;
        end
        bus.din = 16'hE1E2;
        bus.sload_n = 1'b0;
        cyc(1);
        bus.sload_n = 1'b1;
        chk("fc_coinc_stb", {15'd0, sample_stb}, 16'd1);
        chk("fc_coinc_left", {8'd0, left}, 16'hA1);
        chk("fc_coinc_right", {8'd0, right}, 16'hA2);
        cyc(1);
        chk("fc_coinc_over", {15'd0, overflow}, 16'd0);
        load(16'hF1F2);
        chk("fc_over5", {15'd0, overflow}, 16'd1);
        wait_stb(1000, gap);
        chk("fc_d0", {left, right}, 16'hB1B2);
        wait_stb(1000, gap);
        chk("fc_d1", {left, right}, 16'hC1C2);
        wait_stb(1000, gap);
        chk("fc_d2", {left, right}, 16'hD1D2);
        wait_stb(1000, gap);
        chk("fc_d3", {left, right}, 16'hE1E2);
        chk("fc_gap", gap[15:0], 16'd640);

        // rate change 0 -> 3 with div at 1000
        rate = 2'd0; mono = 1'b0;
        restart(1);
        load(16'h1020);
        load(16'h3040);
        load(16'h5060);
        while (en_cnt < 1000) cyc(1);
        cyc(1);
        rate = 2'd3;
        wait_stb(8, gap);
        chk("rc_first_gap", gap[15:0], 16'd4);
        chk("rc_first", {left, right}, 16'h1020);
        wait_stb(1000, gap);
        chk("rc_gap", gap[15:0], 16'd640);
        chk("rc_second", {left, right}, 16'h3040);

        // randomized traffic against the model
        restart(1);
        low_len = 0;
        for (int i = 0; i < 25000; i++) begin
            if (low_len > 0) begin
                low_len--;
                if (low_len == 0) bus.sload_n = 1'b1;
            end else if (bus.sload_n && ((bus.sreq && $urandom_range(0, 7) == 0) ||
                                         $urandom_range(0, 299) == 0)) begin
                bus.din = 16'($urandom);
                bus.sload_n = 1'b0;
                low_len = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 2999) == 0) rate = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1999) == 0) mono = ~mono;
            if ($urandom_range(0, 7999) == 0) sndon = 1'b0;
            else if (!sndon && $urandom_range(0, 3) == 0) sndon = 1'b1;
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
